// File: rtl/lr_shift_seq_pkg.sv
// Shared definitions for the sequential left/right shifter:
// direction/mode encodings, FSM states and a constant clog2.
package lr_shift_seq_pkg;

    typedef enum logic {
        DIR_LEFT  = 1'b0,
        DIR_RIGHT = 1'b1
    } shift_dir_t;

    // Encoding 3 is reserved and behaves as logical.
    typedef enum logic [1:0] {
        MODE_LOGICAL = 2'd0,
        MODE_ARITH   = 2'd1,
        MODE_ROTATE  = 2'd2,
        MODE_RSVD    = 2'd3
    } shift_mode_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    function automatic int clog2(input int n);
        int r;
        int v;
        r = 0;
        v = n - 1;
        while (v > 0) begin
            r = r + 1;
            v = v >> 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/lr_shift_stage.sv
// One power-of-two shifter stage: moves data by 2^k in the given
// direction with zero, sign or wrap-around fill.
module lr_shift_stage
    import lr_shift_seq_pkg::*;
#(
    parameter int width = 8,
    parameter int S     = clog2(width)
) (
    input  logic [width-1:0] data,
    input  logic [S-1:0]     k,
    input  shift_dir_t       dir,
    input  shift_mode_t      mode,
    input  logic             sign,
    output logic [width-1:0] result
);

    logic [2*width-1:0] wide;
    logic [width-1:0]   spill;
    logic               rot;
    logic               fill;
    int                 amt;

    // The half concatenated beside data supplies the incoming bits:
    // a copy of data for rotate, zeros or sign bits otherwise.
    always_comb begin
        amt    = 1 << k;
        rot    = (mode == MODE_ROTATE);
        fill   = (mode == MODE_ARITH) && (dir == DIR_RIGHT) && sign;
        spill  = rot ? data : {width{fill}};
        wide   = '0;
        result = '0;
        if (dir == DIR_LEFT) begin
            wide   = {data, spill} << amt;
            result = wide[2*width-1:width];
        end else begin
            wide   = {spill, data} >> amt;
            result = wide[width-1:0];
        end
    end

endmodule

// File: rtl/lr_shift_seq.sv
// Multi-cycle shifter: resolves one power-of-two stage per clock
// between valid/ready producer and consumer handshakes.
module lr_shift_seq
    import lr_shift_seq_pkg::*;
#(
    parameter int width = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [width-1:0]          iBits,
    input  logic [clog2(width)-1:0]   shift,
    input  logic                      dir,
    input  logic [1:0]                mode,
    input  logic                      iValid,
    output logic                      iReady,
    output logic [width-1:0]          oBits,
    output logic                      oValid,
    input  logic                      oReady
);

    localparam int S = clog2(width);
    localparam logic [S-1:0] K_LAST = S'(S - 1);

    state_t           state;
    state_t           state_nx;
    logic [width-1:0] acc;
    logic [width-1:0] stage_out;
    logic [S-1:0]     k;
    logic [S-1:0]     shift_q;
    shift_dir_t       dir_q;
    shift_mode_t      mode_q;
    logic             sign_q;
    logic             accept;
    logic             stage_en;

    assign accept   = (state == IDLE) && iValid;
    assign stage_en = |(shift_q & (S'(1) << k));

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:    if (iValid)       state_nx = SHIFT;
            SHIFT:   if (k == K_LAST)  state_nx = DONE;
            DONE:    if (oReady)       state_nx = IDLE;
            default:                   state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc     <= '0;
            k       <= '0;
            shift_q <= '0;
            dir_q   <= DIR_LEFT;
            mode_q  <= MODE_LOGICAL;
            sign_q  <= 1'b0;
        end else if (accept) begin
            acc     <= iBits;
            k       <= '0;
            shift_q <= shift;
            dir_q   <= shift_dir_t'(dir);
            mode_q  <= shift_mode_t'(mode);
            sign_q  <= iBits[width-1];
        end else if (state == SHIFT) begin
            if (stage_en) begin
                acc <= stage_out;
            end
            k <= k + 1'b1;
        end
    end

    lr_shift_stage #(
        .width (width),
        .S     (S)
    ) u_stage (
        .data   (acc),
        .k      (k),
        .dir    (dir_q),
        .mode   (mode_q),
        .sign   (sign_q),
        .result (stage_out)
    );

    assign iReady = (state == IDLE);
    assign oValid = (state == DONE);
    assign oBits  = acc;

endmodule

// File: tb/tb_lr_shift_seq.sv
// Directed-vector bench for lr_shift_seq at width 8 and width 6.
// Expected results are hand-computed constants.
module tb_lr_shift_seq;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] bits = '0;
    logic [2:0] shift = '0;
    logic       dir = 1'b0;
    logic [1:0] mode = '0;
    logic       v8 = 1'b0;
    logic       v6 = 1'b0;
    logic       o_ready = 1'b0;
    logic       rdy8, rdy6, ov8, ov6;
    logic [7:0] ob8;
    logic [5:0] ob6;

    int applied = 0;
    int fails = 0;

    always #5 clk = ~clk;

    lr_shift_seq #(.width(8)) dut8 (
        .clk(clk), .rst(rst), .iBits(bits), .shift(shift),
        .dir(dir), .mode(mode), .iValid(v8), .iReady(rdy8),
        .oBits(ob8), .oValid(ov8), .oReady(o_ready)
    );

    lr_shift_seq #(.width(6)) dut6 (
        .clk(clk), .rst(rst), .iBits(bits[5:0]), .shift(shift),
        .dir(dir), .mode(mode), .iValid(v6), .iReady(rdy6),
        .oBits(ob6), .oValid(ov6), .oReady(o_ready)
    );

    typedef struct {
        bit         w6;
        logic [7:0] b;
        logic [2:0] sh;
        logic       d;
        logic [1:0] m;
        logic [7:0] exp;
        string      nm;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        applied++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [7:0] ob(input bit w6);
        return w6 ? {2'b00, ob6} : ob8;
    endfunction

    function automatic logic ov(input bit w6);
        return w6 ? ov6 : ov8;
    endfunction

    function automatic logic rdy(input bit w6);
        return w6 ? rdy6 : rdy8;
    endfunction

    // Accept one operand, scramble inputs, wait for the result,
    // then complete the output handshake.
    task automatic run(input vec_t v, input bit release_out);
        int n;
        @(negedge clk);
        bits = v.b; shift = v.sh; dir = v.d; mode = v.m;
        if (v.w6) v6 = 1'b1; else v8 = 1'b1;
        chk({v.nm, " iReady"}, 32'(rdy(v.w6)), 32'd1);
        @(negedge clk);
        v6 = 1'b0; v8 = 1'b0;
        bits = ~v.b; shift = ~v.sh; dir = ~v.d; mode = v.m ^ 2'b10;
        n = 0;
        while (!ov(v.w6) && n < 12) begin
            @(negedge clk);
            n++;
        end
        chk({v.nm, " latency"}, 32'(n), 32'd3);
        chk({v.nm, " oBits"}, 32'(ob(v.w6)), 32'(v.exp));
        if (release_out) begin
            o_ready = 1'b1;
            @(negedge clk);
            o_ready = 1'b0;
            chk({v.nm, " post oValid"}, 32'(ov(v.w6)), 32'd0);
            chk({v.nm, " post iReady"}, 32'(rdy(v.w6)), 32'd1);
        end
    endtask

    initial begin
        int seen;
        vec_t bp;

        vecs.push_back('{0, 8'hB5, 3'd3, 1'b0, 2'd0, 8'hA8, "lsl3"});
        vecs.push_back('{0, 8'hB5, 3'd2, 1'b1, 2'd1, 8'hED, "asr2"});
        vecs.push_back('{0, 8'hB5, 3'd2, 1'b1, 2'd0, 8'h2D, "lsr2"});
        vecs.push_back('{0, 8'hB5, 3'd2, 1'b1, 2'd3, 8'h2D, "rsv2"});
        vecs.push_back('{0, 8'h81, 3'd1, 1'b0, 2'd2, 8'h03, "rol1"});
        vecs.push_back('{0, 8'h81, 3'd7, 1'b1, 2'd2, 8'h03, "ror7"});
        vecs.push_back('{0, 8'h5A, 3'd0, 1'b1, 2'd1, 8'h5A, "zero"});
        vecs.push_back('{0, 8'h80, 3'd1, 1'b0, 2'd1, 8'h00, "asl1"});
        vecs.push_back('{0, 8'h80, 3'd7, 1'b1, 2'd1, 8'hFF, "asr7n"});
        vecs.push_back('{0, 8'h7F, 3'd7, 1'b1, 2'd1, 8'h00, "asr7p"});
        vecs.push_back('{0, 8'h12, 3'd4, 1'b1, 2'd2, 8'h21, "ror4"});
        vecs.push_back('{0, 8'h01, 3'd7, 1'b0, 2'd0, 8'h80, "lsl7"});
        vecs.push_back('{0, 8'hF0, 3'd5, 1'b1, 2'd0, 8'h07, "lsr5"});
        vecs.push_back('{1, 8'h3F, 3'd7, 1'b0, 2'd0, 8'h00, "w6 lsl7"});
        vecs.push_back('{1, 8'h01, 3'd7, 1'b0, 2'd2, 8'h02, "w6 rol7"});
        vecs.push_back('{1, 8'h20, 3'd7, 1'b1, 2'd1, 8'h3F, "w6 asr7"});
        vecs.push_back('{1, 8'h01, 3'd7, 1'b1, 2'd2, 8'h20, "w6 ror7"});
        vecs.push_back('{1, 8'h3F, 3'd6, 1'b1, 2'd0, 8'h00, "w6 lsr6"});
        vecs.push_back('{1, 8'h05, 3'd2, 1'b0, 2'd2, 8'h14, "w6 rol2"});

        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("reset iReady8", 32'(rdy8), 32'd1);
        chk("reset oValid8", 32'(ov8), 32'd0);
        chk("reset oBits8", 32'(ob8), 32'd0);
        chk("reset iReady6", 32'(rdy6), 32'd1);
        chk("reset oValid6", 32'(ov6), 32'd0);
        chk("reset oBits6", 32'(ob6), 32'd0);

        foreach (vecs[i]) run(vecs[i], 1'b1);

        // Backpressure: result must hold, iValid must be ignored.
        bp = '{0, 8'hB5, 3'd3, 1'b0, 2'd0, 8'hA8, "bp"};
        run(bp, 1'b0);
        for (int c = 0; c < 5; c++) begin
            chk("bp oValid", 32'(ov8), 32'd1);
            chk("bp oBits", 32'(ob8), 32'hA8);
            chk("bp iReady", 32'(rdy8), 32'd0);
            @(negedge clk);
            if (c == 1) begin
                bits = 8'hFF; shift = 3'd0; v8 = 1'b1;
            end else begin
                v8 = 1'b0;
            end
        end
        v8 = 1'b0;
        chk("bp hold oBits", 32'(ob8), 32'hA8);
        o_ready = 1'b1;
        @(negedge clk);
        o_ready = 1'b0;
        chk("bp rel oValid", 32'(ov8), 32'd0);
        chk("bp rel iReady", 32'(rdy8), 32'd1);
        seen = 0;
        repeat (5) begin
            @(negedge clk);
            if (ov8 || !rdy8) seen = 1;
        end
        chk("bp pulse ignored", 32'(seen), 32'd0);

        // Reset in the second SHIFT cycle abandons the operation.
        @(negedge clk);
        bits = 8'hB5; shift = 3'd3; dir = 1'b0; mode = 2'd0; v8 = 1'b1;
        @(negedge clk);
        v8 = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("mid rst oValid", 32'(ov8), 32'd0);
        chk("mid rst iReady", 32'(rdy8), 32'd1);
        seen = 0;
        repeat (6) begin
            @(negedge clk);
            if (ov8) seen = 1;
        end
        chk("mid rst no result", 32'(seen), 32'd0);

        // Reset wins over a simultaneous iValid.
        @(negedge clk);
        rst = 1'b1; v8 = 1'b1;
        @(negedge clk);
        rst = 1'b0; v8 = 1'b0;
        chk("rst prio iReady", 32'(rdy8), 32'd1);
        chk("rst prio oBits", 32'(ob8), 32'd0);

        run(vecs[0], 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", applied, fails);
        $finish;
    end

endmodule
